mvb_loopback_tester: RTL and testbench

- Self-checking traffic generator and checker for the MVB Encode/decode loopback path. Runs on one clock.
- Fills the encoder TX FIFO with a parametrised pattern frame, pulses send_frame, then waits for the decoder frame-over.
- Drains the decoder RX FIFO, compares every word against the regenerated expected pattern, and accumulates pass/fail statistics.
- Replaces the fixed 16-word, single-shot test sequence with configurable width, depth, pattern mode, frame type and repeat count.

---
 rtl/mvb_loopback_tester_if.sv | 31 +++
 rtl/mvb_loopback_tester.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_mvb_loopback_tester.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mvb_loopback_tester_if.sv
// MVB loopback tester bus: encoder TX side and decoder RX side.
// master = tester, slave = encoder/decoder loopback path.
interface mvb_loopback_tester_if #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 7
);
  logic              enc_wr_en;
  logic [DATA_W-1:0] enc_wr_data;
  logic              send_frame;
  logic [LEN_W-1:0]  frame_length;
  logic              s_frame;
  logic              m_frame;
  logic              dec_frame_over;
  logic              dec_err;
  logic              dec_rd_en;
  logic [DATA_W-1:0] dec_rd_data;

  modport master (
    output enc_wr_en, enc_wr_data, send_frame,
    output frame_length, s_frame, m_frame,
    output dec_rd_en,
    input  dec_frame_over, dec_err, dec_rd_data
  );

  modport slave (
    input  enc_wr_en, enc_wr_data, send_frame,
    input  frame_length, s_frame, m_frame,
    input  dec_rd_en,
    output dec_frame_over, dec_err, dec_rd_data
  );
endinterface

// File: rtl/mvb_loopback_tester.sv
// MVB loopback traffic generator and checker.
// Fills TX FIFO with a pattern frame, sends, drains RX FIFO and compares.
module mvb_loopback_tester #(
  parameter int              DATA_W     = 16,
  parameter int              MAX_WORDS  = 32,
  parameter int              LEN_W      = 7,
  parameter logic [DATA_W-1:0] SEED     = 'h7EC3,
  parameter int              GAP_CYCLES = 2000,
  parameter int              TIMEOUT    = 65535,
  localparam int             CW = $clog2(MAX_WORDS+1),
  localparam int             IW = $clog2(MAX_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       num_frames,
  input  logic [CW-1:0]     word_count,
  input  logic [1:0]        mode,
  input  logic              m_sel,
  mvb_loopback_tester_if.master bus,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       fail_cnt,
  output logic [15:0]       word_err_cnt,
  output logic [IW-1:0]     last_bad_idx,
  output logic [DATA_W-1:0] last_bad_data
);

  localparam int TMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX+1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SEND, S_WAIT, S_READ, S_GAP
  } state_t;

  localparam logic [DATA_W-1:0] ONE = 1;

  function automatic logic [DATA_W-1:0] lfsr(
    input logic [DATA_W-1:0] s
  );
    return {s[DATA_W-2:0],
            s[DATA_W-1] ^ s[DATA_W-3] ^ s[DATA_W-4] ^ s[DATA_W-6]};
  endfunction

  function automatic logic [DATA_W-1:0] step_g(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] g
  );
    logic [DATA_W-1:0] r;
    r = g;
    unique case (1'b1)
      (m == 2'd0): r = g + ONE;
      (m == 2'd2): r = lfsr(g);
      default:     r = g;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rot(
    input logic [DATA_W-1:0] w
  );
    return {w[DATA_W-2:0], w[DATA_W-1]};
  endfunction

  // walking-one keeps its own one-hot; other modes live in g
  function automatic logic [DATA_W-1:0] pat(
    input logic [1:0]        m,
    input logic [DATA_W-1:0] g,
    input logic [DATA_W-1:0] w
  );
    return (m == 2'd1) ? (SEED ^ w) : g;
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  state_t            st_q, st_d;
  logic [CW-1:0]     n_q, n_d;
  logic [1:0]        md_q, md_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              send_q, send_d;
  logic [LEN_W-1:0]  flen_q, flen_d;
  logic              sf_q, sf_d;
  logic              mf_q, mf_d;
  logic              rd_en_q, rd_en_d;
  logic              cmp_v_q, cmp_v_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     cidx_q, cidx_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic [DATA_W-1:0] w_q, w_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              fo_prev_q, fo_prev_d;
  logic              fail_q, fail_d;
  logic [15:0]       fc_q, fc_d;
  logic [15:0]       failc_q, failc_d;
  logic [15:0]       werr_q, werr_d;
  logic [IW-1:0]     lbi_q, lbi_d;
  logic [DATA_W-1:0] lbd_q, lbd_d;
  logic              busy_q, busy_d;

  logic              go_fill;
  logic [1:0]        fm;
  logic [CW-1:0]     wc_clamp;
  logic [DATA_W-1:0] exp_w;
  logic              mis;

  always_comb begin
    wc_clamp = word_count;
    if (word_count == '0) begin
      wc_clamp = CW'(1);
    end else if (word_count > CW'(MAX_WORDS)) begin
      wc_clamp = CW'(MAX_WORDS);
    end
  end

  always_comb begin
    st_d      = st_q;
    n_d       = n_q;
    md_d      = md_q;
    wr_en_d   = wr_en_q;
    wr_data_d = wr_data_q;
    send_d    = 1'b0;
    flen_d    = flen_q;
    sf_d      = sf_q;
    mf_d      = mf_q;
    rd_en_d   = rd_en_q;
    cmp_v_d   = rd_en_q;
    cnt_d     = cnt_q;
    cidx_d    = cidx_q;
    g_d       = g_q;
    w_d       = w_q;
    tmr_d     = tmr_q;
    fo_prev_d = bus.dec_frame_over;
    fail_d    = fail_q;
    fc_d      = fc_q;
    failc_d   = failc_q;
    werr_d    = werr_q;
    lbi_d     = lbi_q;
    lbd_d     = lbd_q;
    go_fill   = 1'b0;
    fm        = (st_q == S_IDLE) ? mode : md_q;
    exp_w     = pat(md_q, g_q, w_q);
    mis       = cmp_v_q && (bus.dec_rd_data != exp_w);

    unique case (st_q)
      S_IDLE: begin
        if (start) begin
          n_d     = wc_clamp;
          md_d    = mode;
          sf_d    = ~m_sel;
          mf_d    = m_sel;
          flen_d  = LEN_W'(wc_clamp);
          fc_d    = '0;
          failc_d = '0;
          werr_d  = '0;
          lbi_d   = '0;
          lbd_d   = '0;
          go_fill = 1'b1;
        end
      end
      S_FILL: begin
        if (cnt_q == n_q - CW'(1)) begin
          wr_en_d = 1'b0;
          send_d  = 1'b1;
          st_d    = S_SEND;
        end else begin
          cnt_d     = cnt_q + CW'(1);
          wr_data_d = pat(md_q, g_q, w_q);
          g_d       = step_g(md_q, g_q);
          w_d       = rot(w_q);
        end
      end
      S_SEND: begin
        st_d  = S_WAIT;
        tmr_d = '0;
      end
      S_WAIT: begin
        if (bus.dec_err) begin
          fail_d = 1'b1;
        end
        if (bus.dec_frame_over && !fo_prev_q) begin
          st_d    = S_READ;
          rd_en_d = 1'b1;
          cnt_d   = '0;
          cidx_d  = '0;
          g_d     = SEED;
          w_d     = ONE;
        end else if (tmr_q == TW'(TIMEOUT-1)) begin
          st_d    = S_GAP;
          tmr_d   = '0;
          fc_d    = sat(fc_q);
          failc_d = sat(failc_q);
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_READ: begin
        if (rd_en_q) begin
          if (cnt_q == n_q - CW'(1)) begin
            rd_en_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        // compare trails the read strobe by one clock
        if (cmp_v_q) begin
          g_d    = step_g(md_q, g_q);
          w_d    = rot(w_q);
          cidx_d = cidx_q + CW'(1);
          if (mis) begin
            werr_d = sat(werr_q);
            lbi_d  = cidx_q[IW-1:0];
            lbd_d  = bus.dec_rd_data;
            fail_d = 1'b1;
          end
          if (cidx_q == n_q - CW'(1)) begin
            fc_d  = sat(fc_q);
            st_d  = S_GAP;
            tmr_d = '0;
            if (fail_q || mis) begin
              failc_d = sat(failc_q);
            end
          end
        end
      end
      S_GAP: begin
        if (tmr_q == TW'(GAP_CYCLES-1)) begin
          if (stop || (num_frames != 16'd0 && fc_q == num_frames)) begin
            st_d = S_IDLE;
          end else begin
            go_fill = 1'b1;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: st_d = S_IDLE;
    endcase

    if (go_fill) begin
      st_d      = S_FILL;
      wr_en_d   = 1'b1;
      cnt_d     = '0;
      fail_d    = 1'b0;
      wr_data_d = pat(fm, SEED, ONE);
      g_d       = step_g(fm, SEED);
      w_d       = rot(ONE);
    end

    busy_d = (st_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q      <= S_IDLE;
      n_q       <= '0;
      md_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      send_q    <= 1'b0;
      flen_q    <= '0;
      sf_q      <= 1'b1;
      mf_q      <= 1'b0;
      rd_en_q   <= 1'b0;
      cmp_v_q   <= 1'b0;
      cnt_q     <= '0;
      cidx_q    <= '0;
      g_q       <= '0;
      w_q       <= '0;
      tmr_q     <= '0;
      fo_prev_q <= 1'b0;
      fail_q    <= 1'b0;
      fc_q      <= '0;
      failc_q   <= '0;
      werr_q    <= '0;
      lbi_q     <= '0;
      lbd_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      n_q       <= n_d;
      md_q      <= md_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      send_q    <= send_d;
      flen_q    <= flen_d;
      sf_q      <= sf_d;
      mf_q      <= mf_d;
      rd_en_q   <= rd_en_d;
      cmp_v_q   <= cmp_v_d;
      cnt_q     <= cnt_d;
      cidx_q    <= cidx_d;
      g_q       <= g_d;
      w_q       <= w_d;
      tmr_q     <= tmr_d;
      fo_prev_q <= fo_prev_d;
      fail_q    <= fail_d;
      fc_q      <= fc_d;
      failc_q   <= failc_d;
      werr_q    <= werr_d;
      lbi_q     <= lbi_d;
      lbd_q     <= lbd_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.enc_wr_en    = wr_en_q;
  assign bus.enc_wr_data  = wr_data_q;
  assign bus.send_frame   = send_q;
  assign bus.frame_length = flen_q;
  assign bus.s_frame      = sf_q;
  assign bus.m_frame      = mf_q;
  assign bus.dec_rd_en    = rd_en_q;
  assign busy             = busy_q;
  assign frame_cnt        = fc_q;
  assign fail_cnt         = failc_q;
  assign word_err_cnt     = werr_q;
  assign last_bad_idx     = lbi_q;
  assign last_bad_data    = lbd_q;

endmodule

// File: tb/tb_mvb_loopback_tester.sv
// Bench for mvb_loopback_tester with a behavioural FIFO loopback.
// Vector table of runs plus stop, busy-start and mid-run reset sequences.
module tb_mvb_loopback_tester;

  localparam logic [15:0] SEED = 16'h7EC3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] num_frames;
  logic [5:0]  word_count;
  logic [1:0]  mode;
  logic        m_sel;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [15:0] fail_cnt;
  logic [15:0] word_err_cnt;
  logic [4:0]  last_bad_idx;
  logic [15:0] last_bad_data;

  mvb_loopback_tester_if #(.DATA_W(16), .LEN_W(7)) bus ();

  mvb_loopback_tester #(
    .DATA_W(16), .MAX_WORDS(32), .LEN_W(7), .SEED(SEED),
    .GAP_CYCLES(20), .TIMEOUT(100)
  ) dut (
    .clk(clk), .rst(rst_n), .start(start), .stop(stop),
    .num_frames(num_frames), .word_count(word_count),
    .mode(mode), .m_sel(m_sel), .bus(bus), .busy(busy),
    .frame_cnt(frame_cnt), .fail_cnt(fail_cnt),
    .word_err_cnt(word_err_cnt), .last_bad_idx(last_bad_idx),
    .last_bad_data(last_bad_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // loopback model controls
  bit corrupt, drop, errm;
  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  logic [15:0] wr_log[$];
  int sends, rds, fo_dly;

  initial begin
    sends = 0;
    rds = 0;
    fo_dly = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txq.delete();
      rxq.delete();
      fo_dly = 0;
      bus.dec_frame_over <= 1'b0;
      bus.dec_err        <= 1'b0;
      bus.dec_rd_data    <= 16'h0;
    end else begin
      if (bus.enc_wr_en) begin
        txq.push_back(bus.enc_wr_data);
        wr_log.push_back(bus.enc_wr_data);
      end
      bus.dec_frame_over <= (fo_dly == 1);
      bus.dec_err        <= errm && (fo_dly == 3);
      if (fo_dly != 0) fo_dly = fo_dly - 1;
      if (bus.send_frame) begin
        sends = sends + 1;
        rxq = txq;
        txq.delete();
        if (corrupt && rxq.size() > 5) rxq[5] = 16'h0000;
        fo_dly = drop ? 0 : 4;
      end
      if (bus.dec_rd_en) begin
        rds = rds + 1;
        if (rxq.size() != 0) bus.dec_rd_data <= rxq.pop_front();
        else bus.dec_rd_data <= 16'hDEAD;
      end
    end
  end

  int total, bad;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  function automatic logic [15:0] exp_word(input int m, input int k);
    logic [15:0] v;
    v = SEED;
    case (m)
      0: v = SEED + 16'(k);
      1: v = SEED ^ (16'h1 << (k % 16));
      2: for (int i = 0; i < k; i++) v = lfsr_ref(v);
      default: v = SEED;
    endcase
    return v;
  endfunction

  typedef struct {
    int wc;
    int md;
    bit ms;
    int nf;
    bit cor;
    bit drp;
    bit err;
    int n;
    int fc;
    int fl;
    int werr;
    int lbi;
  } vec_t;

  vec_t vecs[8];

  task automatic wait_idle(input string name);
    for (int c = 0; c < 20000 && busy; c++) @(negedge clk);
    chk({name, "_done"}, busy, 0);
  endtask

  task automatic check_pattern(input string name, input int w0,
                               input int cnt, input int n,
                               input int m);
    int errs;
    errs = 0;
    for (int i = 0; i < cnt; i++) begin
      if (w0 + i >= wr_log.size()) errs++;
      else if (wr_log[w0+i] !== exp_word(m, i % n)) errs++;
    end
    chk({name, "_pattern"}, errs, 0);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int w0, s0, r0, nw;
    corrupt = v.cor;
    drop    = v.drp;
    errm    = v.err;
    w0 = wr_log.size();
    s0 = sends;
    r0 = rds;
    @(negedge clk);
    word_count = 6'(v.wc);
    mode       = 2'(v.md);
    m_sel      = v.ms;
    num_frames = 16'(v.nf);
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, "_busy"}, busy, 1);
    wait_idle(name);
    nw = v.n * v.nf;
    chk({name, "_frame_cnt"}, frame_cnt, v.fc);
    chk({name, "_fail_cnt"}, fail_cnt, v.fl);
    chk({name, "_word_err"}, word_err_cnt, v.werr);
    chk({name, "_lbi"}, last_bad_idx, v.lbi);
    chk({name, "_lbd"}, last_bad_data, 0);
    chk({name, "_flen"}, bus.frame_length, v.n);
    chk({name, "_m_frame"}, bus.m_frame, v.ms);
    chk({name, "_s_frame"}, bus.s_frame, !v.ms);
    chk({name, "_writes"}, wr_log.size() - w0, nw);
    chk({name, "_sends"}, sends - s0, v.nf);
    chk({name, "_reads"}, rds - r0, v.drp ? 0 : nw);
    check_pattern(name, w0, nw, v.n, v.md);
  endtask

  initial begin
    int w0, s0, r0, c;
    total = 0;
    bad = 0;
    corrupt = 0;
    drop = 0;
    errm = 0;
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    num_frames = 16'd1;
    word_count = 6'd16;
    mode = 2'd0;
    m_sel = 1'b0;

    //          wc  md ms nf cor drp err  n  fc fl werr lbi
    vecs[0] = '{16, 0, 0, 1, 0, 0, 0, 16, 1, 0, 0, 0};
    vecs[1] = '{16, 0, 0, 1, 1, 0, 0, 16, 1, 1, 1, 5};
    vecs[2] = '{16, 0, 0, 1, 0, 1, 0, 16, 1, 1, 0, 0};
    vecs[3] = '{0,  1, 1, 1, 0, 0, 0, 1,  1, 0, 0, 0};
    vecs[4] = '{37, 3, 0, 1, 0, 0, 0, 32, 1, 0, 0, 0};
    vecs[5] = '{8,  2, 1, 2, 0, 0, 0, 8,  2, 0, 0, 0};
    vecs[6] = '{20, 1, 0, 1, 0, 0, 0, 20, 1, 0, 0, 0};
    vecs[7] = '{10, 0, 0, 2, 0, 0, 1, 10, 2, 2, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", bus.enc_wr_en, 0);
    chk("rst_wr_data", bus.enc_wr_data, 0);
    chk("rst_send", bus.send_frame, 0);
    chk("rst_flen", bus.frame_length, 0);
    chk("rst_s_frame", bus.s_frame, 1);
    chk("rst_m_frame", bus.m_frame, 0);
    chk("rst_rd_en", bus.dec_rd_en, 0);
    chk("rst_counts", {frame_cnt, fail_cnt, word_err_cnt}, 0);
    chk("rst_last_bad", {last_bad_idx, last_bad_data}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // continuous LFSR run, stray start while busy, stop during frame 3
    corrupt = 0;
    drop = 0;
    errm = 0;
    w0 = wr_log.size();
    s0 = sends;
    @(negedge clk);
    word_count = 6'd4;
    mode = 2'd2;
    m_sel = 1'b0;
    num_frames = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    word_count = 6'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (c = 0; c < 5000 && (sends - s0) < 3; c++) @(negedge clk);
    chk("stop_reach_f3", sends - s0, 3);
    stop = 1'b1;
    wait_idle("stop");
    stop = 1'b0;
    chk("stop_frame_cnt", frame_cnt, 3);
    chk("stop_fail_cnt", fail_cnt, 0);
    chk("stop_word_err", word_err_cnt, 0);
    chk("stop_writes", wr_log.size() - w0, 12);
    chk("stop_flen", bus.frame_length, 4);
    check_pattern("stop", w0, 12, 4, 2);

    // reset in the middle of READ after a mismatch was logged
    corrupt = 1;
    r0 = rds;
    @(negedge clk);
    word_count = 6'd16;
    mode = 2'd0;
    m_sel = 1'b1;
    num_frames = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (c = 0; c < 5000 && (rds - r0) < 10; c++) @(negedge clk);
    chk("rstmid_reading", bus.dec_rd_en, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_rd_en", bus.dec_rd_en, 0);
    chk("rstmid_wr_en", bus.enc_wr_en, 0);
    chk("rstmid_frame", {bus.s_frame, bus.m_frame}, 2'b10);
    chk("rstmid_flen", bus.frame_length, 0);
    chk("rstmid_werr", word_err_cnt, 0);
    chk("rstmid_lbi", last_bad_idx, 0);
    chk("rstmid_fc", frame_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    corrupt = 0;
    repeat (2) @(negedge clk);
    run_vec("post_rst", vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
